// File: rtl/dmem_pkg.sv
// dmem_bridge shared types: FSM states, funct3 size codes, counter width.
// Optional misalignment trap is selected with DMEM_MISALIGN_TRAP_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } dmem_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } dmem_size_t;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam int CNT_W = 8;

  // Unknown funct3 codes fall back to a full word.
  function automatic dmem_size_t size_of(
    input logic [2:0] t
  );
    dmem_size_t s;
    case (t)
      MEM_B, MEM_BU: s = SZ_B;
      MEM_H, MEM_HU: s = SZ_H;
      default:       s = SZ_W;
    endcase
    return s;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] t,
    input logic [1:0] o
  );
    logic m;
    case (size_of(t))
      SZ_H:    m = o[0];
      SZ_W:    m = |o;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables, replicated store data and
// right-justified load word; offset is forced to natural alignment.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_type,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  dmem_size_t w_size;
  logic [1:0] w_off;

  always_comb begin
    w_size  = size_of(i_type);
    w_off   = i_off;
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (w_size)
      SZ_B: begin
        o_be    = 4'b0001 << w_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        w_off   = {i_off[1], 1'b0};
        o_be    = 4'b0011 << w_off;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        w_off   = 2'b00;
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
    o_rdata = i_rword >> {w_off, 3'b000};
  end

endmodule

// File: rtl/dmem_bridge.sv
// CPU stage-3 to word SRAM bridge: lane alignment, req/ack sequencing,
// timeout abort. Define DMEM_MISALIGN_TRAP_EN to trap misaligned H/W.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wr_data,
  input  logic [2:0]        cpu_type,
  input  logic              cpu_rd_en,
  input  logic              cpu_wr_en,
  output logic [31:0]       cpu_rd_data,
  output logic              stall,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  dmem_state_t       r_state;
  dmem_state_t       w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_off;
  logic [2:0]        r_type;
  logic [31:0]       r_data;
  logic [31:0]       r_rd;

  logic              w_req_in;
  logic              w_mis;
  logic              w_to;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_req_in = cpu_rd_en | cpu_wr_en;
  assign w_to     = (r_cnt == TO_LAST);
  assign w_unused = ^{cpu_addr[31:ADDR_W+2]};

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_mis = misaligned(cpu_type, cpu_addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  dmem_lane_align u_align (
    .i_type  (r_type),
    .i_off   (r_off),
    .i_wdata (r_data),
    .i_rword (mem_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = w_req_in;
        if (w_req_in) w_next = w_mis ? S_RESP : S_REQ;
      end
      S_REQ: begin
        stall = 1'b1;
        if (mem_ack || w_to) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_req  <= 1'b0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_off  <= 2'b00;
      r_type <= 3'b000;
      r_data <= 32'h0;
      r_rd   <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_in) begin
            r_addr <= cpu_addr[ADDR_W+1:2];
            r_off  <= cpu_addr[1:0];
            r_type <= cpu_type;
            r_data <= cpu_wr_data;
            r_we   <= cpu_wr_en;
            r_cnt  <= '0;
            if (w_mis) begin
              r_err <= 1'b1;
              if (!cpu_wr_en) r_rd <= 32'h0;
            end else begin
              r_req <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_req <= 1'b0;
            if (!r_we) r_rd <= w_rdata;
          end else if (w_to) begin
            r_req <= 1'b0;
            r_err <= 1'b1;
            r_rd  <= 32'h0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Lane outputs idle at zero whenever no request is on the bus.
  assign mem_req     = r_req;
  assign mem_we      = r_req & r_we;
  assign mem_addr    = r_addr;
  assign mem_be      = r_req ? (r_we ? w_be : 4'b1111) : 4'b0000;
  assign mem_wdata   = (r_req & r_we) ? w_wdata : 32'h0;
  assign cpu_rd_data = r_rd;
  assign bus_err     = r_err;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed vector bench for dmem_bridge (TIMEOUT=4).
// Table rows cover single accesses; hand sequences cover reset corners.
module tb_dmem_bridge;

  logic        CLK;
  logic        rst;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wr_data;
  logic [2:0]  cpu_type;
  logic        cpu_rd_en;
  logic        cpu_wr_en;
  logic [31:0] cpu_rd_data;
  logic        stall;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp;
  int n_bad;

  dmem_bridge #(.ADDR_W(16), .TIMEOUT(4)) dut (
    .CLK         (CLK),
    .rst         (rst),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_type    (cpu_type),
    .cpu_rd_en   (cpu_rd_en),
    .cpu_wr_en   (cpu_wr_en),
    .cpu_rd_data (cpu_rd_data),
    .stall       (stall),
    .bus_err     (bus_err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    int          e_stall;
    int          e_reqc;
    logic [15:0] e_maddr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic        e_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rd, input logic wr, input logic [2:0] typ,
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic [31:0] rdata, input int lat, input int e_stall,
    input int e_reqc, input logic [15:0] e_maddr, input logic [3:0] e_be,
    input logic e_we, input logic [31:0] e_wd, input logic [31:0] e_rd,
    input logic e_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.typ = typ; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.lat = lat; v.e_stall = e_stall; v.e_reqc = e_reqc;
    v.e_maddr = e_maddr; v.e_be = e_be; v.e_we = e_we; v.e_wd = e_wd;
    v.e_rd = e_rd; v.e_err = e_err;
    return v;
  endfunction

  task automatic run(input vec_t v, input string nm);
    int          st;
    int          rc;
    logic        stab;
    logic        done;
    logic [15:0] a0;
    logic [3:0]  b0;
    logic        w0;
    logic [31:0] d0;
    st = 0; rc = 0; stab = 1'b1; done = 1'b0;
    a0 = '0; b0 = '0; w0 = 1'b0; d0 = '0;
    @(negedge CLK);
    cpu_rd_en   = v.rd;
    cpu_wr_en   = v.wr;
    cpu_type    = v.typ;
    cpu_addr    = v.addr;
    cpu_wr_data = v.wdata;
    #1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (!stall) begin
        done = 1'b1;
      end else begin
        st++;
        mem_ack   = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        if (mem_req) begin
          if (rc == 0) begin
            a0 = mem_addr; b0 = mem_be; w0 = mem_we; d0 = mem_wdata;
          end else if (mem_addr !== a0 || mem_be !== b0 ||
                       mem_we !== w0 || mem_wdata !== d0) begin
            stab = 1'b0;
          end
          if (rc == v.lat) begin
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
          end
          rc++;
        end
        @(negedge CLK);
        #1;
      end
    end
    chk({nm, ".done"}, 32'(done), 32'd1);
    chk({nm, ".stall_cyc"}, st, v.e_stall);
    chk({nm, ".req_cyc"}, rc, v.e_reqc);
    chk({nm, ".stable"}, 32'(stab), 32'd1);
    chk({nm, ".bus_err"}, 32'(bus_err), 32'(v.e_err));
    chk({nm, ".req_in_resp"}, 32'(mem_req), 32'd0);
    if (v.e_reqc > 0) begin
      chk({nm, ".addr"}, 32'(a0), 32'(v.e_maddr));
      chk({nm, ".be"}, 32'(b0), 32'(v.e_be));
      chk({nm, ".we"}, 32'(w0), 32'(v.e_we));
      if (v.e_we) chk({nm, ".wdata"}, d0, v.e_wd);
    end
    if (!v.e_we) chk({nm, ".rd_data"}, cpu_rd_data, v.e_rd);
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
    mem_ack   = 1'b0;
  endtask

  vec_t tbl [10];
  vec_t mis;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    cpu_addr = '0; cpu_wr_data = '0; cpu_type = 3'b010;
    cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;

    tbl[0] = mk(0,1,3'b010,32'h10,32'h1234_5678,0,0,2,1,16'h4,4'hF,1,32'h1234_5678,0,0);
    tbl[1] = mk(0,1,3'b000,32'h13,32'h0000_00AB,0,0,2,1,16'h4,4'h8,1,32'hABAB_ABAB,0,0);
    tbl[2] = mk(1,0,3'b001,32'h12,0,32'hBEEF_1234,0,2,1,16'h4,4'hF,0,0,32'h0000_BEEF,0);
    tbl[3] = mk(0,1,3'b010,32'h20,32'hCAFE_F00D,0,3,5,4,16'h8,4'hF,1,32'hCAFE_F00D,0,0);
    tbl[4] = mk(0,1,3'b001,32'h2,32'h1234_5678,0,0,2,1,16'h0,4'hC,1,32'h5678_5678,0,0);
    tbl[5] = mk(1,0,3'b000,32'h101,0,32'h1122_3344,0,2,1,16'h40,4'hF,0,0,32'h0011_2233,0);
    tbl[6] = mk(1,0,3'b100,32'h3,0,32'hA1B2_C3D4,1,3,2,16'h0,4'hF,0,0,32'h0000_00A1,0);
    tbl[7] = mk(1,1,3'b010,32'h0004_0008,32'h0BAD_BEEF,0,0,2,1,16'h2,4'hF,1,32'h0BAD_BEEF,0,0);
    tbl[8] = mk(1,0,3'b011,32'h8,0,32'h55AA_55AA,2,4,3,16'h2,4'hF,0,0,32'h55AA_55AA,0);
    tbl[9] = mk(1,0,3'b010,32'h0,0,32'h1111_1111,99,5,4,16'h0,4'hF,0,0,32'h0,1);

`ifdef DMEM_MISALIGN_TRAP_EN
    mis = mk(1,0,3'b010,32'h11,0,32'hDEAD_BEEF,0,1,0,16'h0,4'h0,0,0,32'h0,1);
`else
    mis = mk(1,0,3'b010,32'h11,0,32'hDEAD_BEEF,0,2,1,16'h4,4'hF,0,0,32'hDEAD_BEEF,0);
`endif

    repeat (2) @(negedge CLK);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", 32'(mem_addr), 32'd0);
    chk("rst.mem_be", 32'(mem_be), 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.rd_data", cpu_rd_data, 32'd0);
    chk("rst.bus_err", 32'(bus_err), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("vec%0d", i));

    @(negedge CLK);
    rst = 1'b1;
    #1;
    chk("clr.bus_err", 32'(bus_err), 32'd0);
    chk("clr.rd_data", cpu_rd_data, 32'd0);
    @(negedge CLK);
    rst = 1'b0;

    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge CLK);
    #1;
    chk("idle_ack.req", 32'(mem_req), 32'd0);
    chk("idle_ack.stall", 32'(stall), 32'd0);
    chk("idle_ack.rd_data", cpu_rd_data, 32'd0);
    mem_ack = 1'b0;

    @(negedge CLK);
    cpu_rd_en = 1'b1; cpu_type = 3'b010; cpu_addr = 32'h4;
    @(negedge CLK);
    #1;
    chk("midrst.req_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst.req_after", 32'(mem_req), 32'd0);
    chk("midrst.be_after", 32'(mem_be), 32'd0);
    cpu_rd_en = 1'b0;
    @(negedge CLK);
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h7777_7777;
    @(negedge CLK);
    #1;
    chk("late_ack.req", 32'(mem_req), 32'd0);
    chk("late_ack.stall", 32'(stall), 32'd0);
    chk("late_ack.rd_data", cpu_rd_data, 32'd0);
    mem_ack = 1'b0;

    run(mis, "misalign_lw");

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge between the CPU's stage-3 memory port (`MEM_addr`, `MEM_WR_out`, `MEM_type`, `MEM_rd_en`, `MEM_wr_en`, `MEM_data`) and a word-organised, variable-latency data SRAM/bus with a req/ack handshake. It performs byte-lane alignment, byte-enable generation and transaction sequencing. It raises a stall while an access is outstanding; the CPU holds stage 3 for as long as stall is high. Sign/zero extension of loads stays in the CPU's memory controller.

## Interface
- `ADDR_W`, 16: word-address width presented to memory (byte address bits [ADDR_W+1:2]).
- `TIMEOUT`, 255: maximum REQ cycles without ack before abort; must be ≥1 and fit 8 bits.
- `CLK`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cpu_addr`  in  32  byte address (CPU `MEM_addr`).
- `cpu_wr_data`  in  32  store data, value right-justified (CPU `MEM_WR_out`).
- `cpu_type`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are treated as W.
- `cpu_rd_en`, `cpu_wr_en`  in  1 each  load/store request (level, held while stalled).
- `cpu_rd_data`  out  32  word right-shifted by byte offset ×8, zero-filled (to CPU `MEM_data`).
- `stall`  out  1  CPU must hold stage 3.
- `bus_err`  out  1  sticky; set on timeout (and on misalignment when trap is enabled).
- `mem_req`  out  1; `mem_we`  out  1; `mem_addr`  out  ADDR_W; `mem_be`  out  4; `mem_wdata`  out  32.
- `mem_ack`  in  1; `mem_rdata`  in  32  valid in the ack cycle.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE, request (rd_en|wr_en) present:
  - Latch address, type, data and direction; go to REQ.
  - If rd_en and wr_en are both high, perform a write.
- REQ:
  - Drive mem_req=1 with all mem_* signals stable, driven from registers.
  - mem_ack → capture mem_rdata (reads only), go to RESP.
- RESP: present the response for one cycle, then go to IDLE unconditionally. The held CPU request is not re-issued.
- Timeout:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT: drop req, set bus_err, load 32'h0 as read data, go to RESP.
- Write lanes, with offset o = addr[1:0]:
  - B: be = 4'b0001<<o; wdata = {4{data[7:0]}}.
  - H: be = 4'b0011<<o; wdata = {2{data[15:0]}}.
  - W: be = 4'b1111.
- mem_be = 4'b1111 for reads.
- cpu_rd_data = captured word >> (8·o); the register holds its value until the next capture.
- Reset values:
  - State IDLE; counter 0; bus_err 0.
  - mem_req, mem_we = 0; mem_addr, mem_be, mem_wdata = 0.
  - cpu_rd_data = 0.
- Assertion of rst mid-REQ drops mem_req immediately, because it is asynchronous. A late ack after reset is ignored.
- An ack in IDLE or RESP is ignored.
- Address bits above ADDR_W+1 are discarded; addresses wrap modulo memory size.

## Timing
- stall = (IDLE & (rd_en|wr_en)) | REQ; this is combinational from the request inputs.
- stall is 0 in RESP, so stage 3 advances at the end of RESP.
- Zero-wait memory (ack in the first REQ cycle):
  - Request seen in cycle 0; mem_req in cycle 1; RESP in cycle 2.
  - 2 stall cycles in total.
- Each extra wait cycle adds one stall cycle.
- A back-to-back request in the cycle after RESP starts a new access from IDLE.
- mem_* signals are registered outputs with no combinational path from cpu_* to mem_*.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A misaligned H (o odd) or W (o≠0) access skips REQ and goes IDLE→RESP with bus_err set.
  - Reads return 0; writes are dropped.
- Not defined: the offset is forced to natural alignment (H clears bit 0, W clears bits [1:0]) and the access proceeds normally.

## Structure
- Package `dmem_pkg`:
  - State enum `dmem_state_t`.
  - Funct3 size constants (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU).
  - Timeout counter width.
- Sub-module `dmem_lane_align`: combinational; takes type and offset; produces be, replicated wdata and shifted read data. This module is instantiated once.

## Test plan
- SW 0x12345678 to byte address 0x10, ack in first REQ cycle → mem_addr=4, be=1111, wdata=0x12345678, stall high exactly 2 cycles.
- SB data 0xAB to byte address 0x13 → be=1000, wdata=0xABABABAB.
- LH from byte address 0x12 with mem_rdata 0xBEEF1234 → cpu_rd_data=0x0000BEEF in RESP; stall falls in RESP.
- Ack delayed 3 cycles → mem_req and mem_* held stable for 4 REQ cycles, 5 stall cycles total.
- No ack with TIMEOUT=4 → req drops after 4 REQ cycles, bus_err=1, cpu_rd_data=0; rst clears bus_err.
- LW from byte address 0x11:
  - Macro defined → no mem_req, bus_err=1.
  - Macro undefined → mem_addr=4, normal read.
